// File: rtl/gonso_sequencer_if.sv
// Memory read bus between gonso_sequencer (master) and the byte buffer (slave).
// rdata is valid the cycle after cs_n is low.
interface gonso_sequencer_if #(
  parameter int ASIZE = 32
);
  logic             cs_n;
  logic [ASIZE-1:0] addr;
  logic [7:0]       rdata;

  modport master (output cs_n, output addr, input rdata);
  modport slave  (input cs_n, input addr, output rdata);
endinterface

// File: rtl/gonso_sequencer.sv
// Serialises a memory buffer onto dout, repeated w_count times, at a prescaled bit rate.
// Define GONSO_SEQ_LSB_FIRST_EN to shift each byte LSB first instead of MSB first.
module gonso_sequencer #(
  parameter int ASIZE = 32,
  parameter int PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             controller_en,
  input  logic [PSIZE-1:0] prescaler,
  input  logic             polarity,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  input  logic             start,
  output logic             progress,
  output logic             dout,
  output logic             bit_strobe,
  gonso_sequencer_if.master mem
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  localparam logic [ASIZE-1:0] ADDR_ONE = {{(ASIZE-1){1'b0}}, 1'b1};
  localparam logic [PSIZE-1:0] TICK_ONE = {{(PSIZE-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [ASIZE-1:0] first_q, first_d;
  logic [ASIZE-1:0] last_q, last_d;
  logic [PSIZE-1:0] presc_q, presc_d;
  logic [PSIZE-1:0] tick_q, tick_d;
  logic [3:0]       pass_q, pass_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shiftReg_q, shiftReg_d;
  logic             dout_q, dout_d;
  logic             strobe_q, strobe_d;
  logic             outBit;

  assign progress   = (state_q != IDLE);
  assign mem.cs_n   = (state_q != FETCH);
  assign mem.addr   = addr_q;
  assign dout       = dout_q;
  assign bit_strobe = strobe_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    first_d    = first_q;
    last_d     = last_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    pass_d     = pass_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    if (!controller_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (w_count != 4'd0)) begin
            first_d = w_first;
            last_d  = w_last;
            presc_d = prescaler;
            pass_d  = w_count;
            addr_d  = w_first;
            state_d = FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          shiftReg_d = mem.rdata;
          tick_d     = '0;
          bitIdx_d   = 3'd0;
          state_d    = SHIFT;
        end
        SHIFT: begin
          if (tick_q == presc_q) begin
            tick_d = '0;
            if (bitIdx_q == 3'd7) begin
              // End of byte: advance within the pass, or start the next pass.
              if (addr_q != last_q) begin
                addr_d  = addr_q + ADDR_ONE;
                state_d = FETCH;
              end else begin
                pass_d = pass_q - 4'd1;
                if (pass_q != 4'd1) begin
                  addr_d  = first_q;
                  state_d = FETCH;
                end else begin
                  state_d = IDLE;
                end
              end
            end else begin
              bitIdx_d = bitIdx_q + 3'd1;
`ifdef GONSO_SEQ_LSB_FIRST_EN
              shiftReg_d = {1'b0, shiftReg_q[7:1]};
`else
              shiftReg_d = {shiftReg_q[6:0], 1'b0};
`endif
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
`ifdef GONSO_SEQ_LSB_FIRST_EN
  assign outBit = shiftReg_d[0];
`else
  assign outBit = shiftReg_d[7];
`endif

  always_comb begin
    dout_d   = (state_d == SHIFT) ? (outBit ^ polarity) : polarity;
    strobe_d = (state_d == SHIFT) && (tick_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      first_q    <= '0;
      last_q     <= '0;
      presc_q    <= '0;
      tick_q     <= '0;
      pass_q     <= 4'd0;
      bitIdx_q   <= 3'd0;
      shiftReg_q <= 8'd0;
      dout_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      pass_q     <= pass_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      dout_q     <= dout_d;
      strobe_q   <= strobe_d;
    end
  end

endmodule

// File: tb/tb_gonso_sequencer.sv
// Directed bench for gonso_sequencer: table of whole sequences plus hand-written
// sequences for enable drop and mid-byte reset.
module tb_gonso_sequencer;

  typedef struct {
    logic [31:0]      presc;
    logic             pol;
    logic [3:0]       cnt;
    logic [31:0]      aFirst;
    logic [31:0]      aLast;
    int               nAddr;
    logic [5:0][31:0] addrs;
    int               expProgress;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        controller_en;
  logic [31:0] prescaler;
  logic        polarity;
  logic [3:0]  w_count;
  logic [31:0] w_first;
  logic [31:0] w_last;
  logic        start;
  logic        progress;
  logic        dout;
  logic        bit_strobe;

  int nCompared;
  int nMismatched;

  logic [31:0] seenAddr[$];
  logic        seenBits[$];
  int          progCycles;
  int          holdErr;
  logic        timedOut;

  vec_t vecs[6];

  gonso_sequencer_if #(.ASIZE(32)) memBus ();

  gonso_sequencer #(.ASIZE(32), .PSIZE(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .controller_en (controller_en),
    .prescaler     (prescaler),
    .polarity      (polarity),
    .w_count       (w_count),
    .w_first       (w_first),
    .w_last        (w_last),
    .start         (start),
    .progress      (progress),
    .dout          (dout),
    .bit_strobe    (bit_strobe),
    .mem           (memBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the sequencer
  function automatic logic [7:0] memByte(input logic [31:0] a);
    case (a)
      32'h0000_0010: memByte = 8'hA5;
      32'h0000_0020: memByte = 8'h3C;
      32'h0000_0021: memByte = 8'h81;
      32'h0000_0022: memByte = 8'hF0;
      32'h0000_0030: memByte = 8'h00;
      32'hFFFF_FFFF: memByte = 8'h5A;
      32'h0000_0000: memByte = 8'hC3;
      32'h0000_0001: memByte = 8'h96;
      default:       memByte = a[7:0] ^ 8'h55;
    endcase
  endfunction

  // Synchronous read: data valid the cycle after cs_n is low
  always @(posedge clk) begin
    if (!memBus.cs_n) memBus.rdata <= memByte(memBus.addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one full sequence, recording addresses, strobed bits and timing.
  task automatic applyStimulus(input vec_t v);
    logic curBit;
    logic prevCsLow;
    logic seen;
    logic inShift;
    seenAddr.delete();
    seenBits.delete();
    progCycles = 0;
    holdErr    = 0;
    timedOut   = 1'b0;
    curBit     = v.pol;
    prevCsLow  = 1'b0;
    seen       = 1'b0;
    @(negedge clk);
    prescaler = v.presc;
    polarity  = v.pol;
    w_count   = v.cnt;
    w_first   = v.aFirst;
    w_last    = v.aLast;
    start     = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        if (v.cnt != 4'd0) begin
          prescaler = 32'd7;
          w_count   = 4'd5;
          w_first   = 32'h40;
          w_last    = 32'h41;
        end
      end
      if (i == 4 && v.cnt != 4'd0) start = 1'b1;
      if (i == 5) start = 1'b0;
      inShift = progress && memBus.cs_n && !prevCsLow;
      if (progress) begin
        seen = 1'b1;
        progCycles++;
      end
      if (!memBus.cs_n) seenAddr.push_back(memBus.addr);
      if (bit_strobe) begin
        seenBits.push_back(dout);
        curBit = dout;
      end else if (inShift) begin
        if (dout !== curBit) holdErr++;
      end else if (dout !== v.pol) begin
        holdErr++;
      end
      prevCsLow = !memBus.cs_n;
      if (seen && !progress) break;
      if (!seen && v.expProgress == 0 && i >= 20) break;
      if (i == 2999) timedOut = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [7:0] expByte;
    logic [7:0] obsByte;
    int nBytes;
    check($sformatf("v%0d timeout", idx), timedOut, 1'b0);
    check($sformatf("v%0d addrCount", idx), seenAddr.size(), v.nAddr);
    check($sformatf("v%0d progressCycles", idx), progCycles, v.expProgress);
    check($sformatf("v%0d bitCount", idx), seenBits.size(), v.nAddr * 8);
    check($sformatf("v%0d doutHold", idx), holdErr, 0);
    check($sformatf("v%0d idleDout", idx), dout, v.pol);
    nBytes = (seenAddr.size() < v.nAddr) ? seenAddr.size() : v.nAddr;
    for (int k = 0; k < nBytes; k++) begin
      check($sformatf("v%0d addr%0d", idx, k), seenAddr[k], v.addrs[k]);
    end
    nBytes = (seenBits.size() / 8 < v.nAddr) ? seenBits.size() / 8 : v.nAddr;
    for (int k = 0; k < nBytes; k++) begin
      obsByte = 8'h00;
      for (int b = 0; b < 8; b++) obsByte = {obsByte[6:0], seenBits[8*k+b]};
      expByte = memByte(v.addrs[k]) ^ {8{v.pol}};
      check($sformatf("v%0d byte%0d", idx, k), obsByte, expByte);
    end
  endtask

  task automatic waitIdle(input string name);
    int i;
    i = 0;
    while (progress && i < 500) begin
      @(negedge clk);
      i++;
    end
    check(name, progress, 1'b0);
  endtask

  initial begin
    int strobes;
    int busyCycles;
    int csLowCycles;
    nCompared   = 0;
    nMismatched = 0;

    vecs[0] = '{presc: 32'd3, pol: 1'b0, cnt: 4'd1, aFirst: 32'h10, aLast: 32'h10, nAddr: 1,
                addrs: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10}, expProgress: 34};
    vecs[1] = '{presc: 32'd0, pol: 1'b0, cnt: 4'd2, aFirst: 32'h20, aLast: 32'h22, nAddr: 6,
                addrs: {32'h22, 32'h21, 32'h20, 32'h22, 32'h21, 32'h20}, expProgress: 60};
    vecs[2] = '{presc: 32'd1, pol: 1'b1, cnt: 4'd1, aFirst: 32'h30, aLast: 32'h30, nAddr: 1,
                addrs: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h30}, expProgress: 18};
    vecs[3] = '{presc: 32'd0, pol: 1'b0, cnt: 4'd1, aFirst: 32'hFFFF_FFFF, aLast: 32'h1, nAddr: 3,
                addrs: {32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF}, expProgress: 30};
    vecs[4] = '{presc: 32'd2, pol: 1'b1, cnt: 4'd3, aFirst: 32'h10, aLast: 32'h10, nAddr: 3,
                addrs: {32'h0, 32'h0, 32'h0, 32'h10, 32'h10, 32'h10}, expProgress: 78};
    vecs[5] = '{presc: 32'd1, pol: 1'b1, cnt: 4'd0, aFirst: 32'h30, aLast: 32'h30, nAddr: 0,
                addrs: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, expProgress: 0};

    rst_n         = 1'b0;
    controller_en = 1'b1;
    prescaler     = 32'd0;
    polarity      = 1'b1;
    w_count       = 4'd0;
    w_first       = 32'h0;
    w_last        = 32'h0;
    start         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset progress", progress, 1'b0);
    check("reset cs_n", memBus.cs_n, 1'b1);
    check("reset addr", memBus.addr, 32'h0);
    check("reset dout", dout, 1'b0);
    check("reset bit_strobe", bit_strobe, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle dout after reset", dout, 1'b1);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n]);
      checkOutput(n, vecs[n]);
    end

    // Enable dropped during bit 3 of the first byte, then a clean restart
    @(negedge clk);
    prescaler = 32'd3;
    polarity  = 1'b1;
    w_count   = 4'd1;
    w_first   = 32'h10;
    w_last    = 32'h12;
    start     = 1'b1;
    strobes   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (bit_strobe) strobes++;
      if (strobes == 3) break;
    end
    check("abort reached bit 3", strobes, 3);
    check("abort busy before drop", progress, 1'b1);
    controller_en = 1'b0;
    @(negedge clk);
    check("abort progress", progress, 1'b0);
    check("abort cs_n", memBus.cs_n, 1'b1);
    check("abort dout", dout, 1'b1);
    controller_en = 1'b1;
    w_first       = 32'h20;
    w_last        = 32'h20;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart cs_n", memBus.cs_n, 1'b0);
    check("restart addr", memBus.addr, 32'h20);
    waitIdle("restart completes");

    // Reset mid-byte, with a start pulse arriving while busy beforehand
    @(negedge clk);
    prescaler = 32'd3;
    polarity  = 1'b1;
    w_count   = 4'd2;
    w_first   = 32'h10;
    w_last    = 32'h11;
    start     = 1'b1;
    strobes   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (bit_strobe) strobes++;
      if (strobes == 2) break;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy before reset", progress, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset progress", progress, 1'b0);
    check("midreset cs_n", memBus.cs_n, 1'b1);
    check("midreset addr", memBus.addr, 32'h0);
    check("midreset dout", dout, 1'b0);
    check("midreset bit_strobe", bit_strobe, 1'b0);
    @(negedge clk);
    rst_n       = 1'b1;
    busyCycles  = 0;
    csLowCycles = 0;
    repeat (12) begin
      @(negedge clk);
      if (progress) busyCycles++;
      if (!memBus.cs_n) csLowCycles++;
    end
    check("post-reset progress cycles", busyCycles, 0);
    check("post-reset cs_n low cycles", csLowCycles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/gonso_sequencer.md
GONSO_SEQUENCER -- requirements
Module: gonso_sequencer

Interface
REQ-001 SHALL have parameter ASIZE, default 32, memory buffer address width in bits.
REQ-002 SHALL have parameter PSIZE, default 32, prescaler width in bits.
REQ-003 SHALL have port clk  in  1  clock, rising edge; the block's single clock.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active low.
REQ-005 SHALL have port controller_en  in  1  enable, active high.
REQ-006 SHALL have port prescaler  in  PSIZE  bit period in clocks, minus 1.
REQ-007 SHALL have port polarity  in  1  output inversion; also the idle level.
REQ-008 SHALL have port w_count  in  4  number of passes over the buffer.
REQ-009 SHALL have port w_first  in  ASIZE  first byte address.
REQ-010 SHALL have port w_last  in  ASIZE  last byte address, inclusive.
REQ-011 SHALL have port start  in  1  start strobe, one cycle.
REQ-012 SHALL have port progress  out  1  high while a sequence is active.
REQ-013 SHALL have port cs_n  out  1  memory chip select, active low.
REQ-014 SHALL have port addr  out  ASIZE  memory read address.
REQ-015 SHALL have port rdata  in  8  memory read data, valid the cycle after cs_n is low.
REQ-016 SHALL have port dout  out  1  serial bit output.
REQ-017 SHALL have port bit_strobe  out  1  one-cycle pulse on the first cycle of each bit.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, LOAD, SHIFT.
REQ-019 SHALL move from IDLE to FETCH when start=1, controller_en=1 and w_count!=0; otherwise start SHALL be ignored.
REQ-020 SHALL latch prescaler, w_count, w_first and w_last on accepted start; later changes to these inputs SHALL NOT affect the running sequence.
REQ-021 SHALL hold progress=1 in FETCH, LOAD and SHIFT, and progress=0 in IDLE.
REQ-022 SHALL drive cs_n=0 for exactly the one FETCH cycle, with addr = current byte address; cs_n SHALL be 1 in all other cycles.
REQ-023 SHALL capture rdata into an 8-bit shift register in LOAD, then enter SHIFT.
REQ-024 SHALL hold each bit on dout for prescaler+1 cycles, as dout = bit XOR polarity, and pulse bit_strobe on each bit's first cycle.
REQ-025 SHALL shift MSB first (default build); byte period = 8*(prescaler+1)+2 cycles.
REQ-026 SHALL, after bit 8 ends and address != latched w_last, increment the address modulo 2^ASIZE and go to FETCH; w_last < w_first therefore wraps through 0.
REQ-027 SHALL, after bit 8 ends and address == w_last, decrement the pass counter; if it is nonzero it SHALL reload w_first and go to FETCH, otherwise go to IDLE.
REQ-028 SHALL drive dout = polarity when not in SHIFT.
REQ-029 SHALL ignore start while progress=1.
REQ-030 SHALL, if controller_en falls in any state, return to IDLE on the next edge (progress=0, cs_n=1, dout=polarity) without completing the byte.
REQ-031 SHALL treat prescaler=0 as one-cycle bits, with bit_strobe high for every SHIFT cycle.
REQ-032 SHALL, for w_first == w_last, send one byte per pass.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously set state=IDLE, progress=0, cs_n=1, addr=0, dout=0, bit_strobe=0, and clear the shift register, pass counter and latched configuration.
REQ-034 SHALL abort a running sequence on reset mid-operation; after release it SHALL wait for a new start.

Configuration
REQ-035 SHALL, when macro GONSO_SEQ_LSB_FIRST_EN is defined, shift each byte LSB first.
REQ-036 SHALL, when GONSO_SEQ_LSB_FIRST_EN is undefined, shift each byte MSB first; all timing is identical in both builds.

Verification
REQ-037 SHALL test: prescaler=3, w_first=w_last=0x10, w_count=1, mem[0x10]=0xA5, polarity=0 -> one cs_n pulse at addr 0x10; dout=1,0,1,0,0,1,0,1, each held 4 cycles; progress high for 34 cycles.
REQ-038 SHALL test: w_first=0x20, w_last=0x22, w_count=2, prescaler=0 -> addr sequence 0x20,0x21,0x22,0x20,0x21,0x22; 48 bit_strobe pulses; progress then low.
REQ-039 SHALL test: polarity=1, byte 0x00 -> dout=1 for all bits and in idle; same stimulus with w_count=0 -> progress stays 0 and cs_n stays 1.
REQ-040 SHALL test: w_first=0xFFFFFFFF, w_last=0x00000001, w_count=1 -> reads 0xFFFFFFFF, 0x0, 0x1, then IDLE.
REQ-041 SHALL test: controller_en dropped at bit 3 of the first byte -> next cycle progress=0, cs_n=1, dout=polarity; a new start then restarts at w_first.
REQ-042 SHALL test: rst_n asserted mid-byte -> outputs take REQ-033 values immediately, and a start pulse received while busy before the reset has no effect.
